// File: rtl/sample_source.sv
`default_nettype none
// ============================================================================
// Module      : sample_source
// Description : Programmable 8-bit sample generator with valid/ready output.
// Revision    : 1.0
// ============================================================================
module sample_source #(
  parameter int         CNT_W     = 16,
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [CNT_W-1:0] num_samples,
  input  logic [7:0]       step,
  input  logic [7:0]       const_val,
  input  logic [3:0]       gap,
  output logic             o_valid,
  input  logic             o_ready,
  output logic [7:0]       o_data,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] sent_count
);

  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_run  = 2'd1;
  localparam logic [1:0] c_st_gap  = 2'd2;
  localparam logic [1:0] c_st_done = 2'd3;

  localparam logic [1:0] c_mode_ramp  = 2'b00;
  localparam logic [1:0] c_mode_lfsr  = 2'b01;
  localparam logic [1:0] c_mode_const = 2'b10;

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [1:0]       r_mode;
  logic [CNT_W-1:0] r_num;
  logic [7:0]       r_step;
  logic [7:0]       r_const;
  logic [3:0]       r_gap;
  logic [3:0]       r_gap_cnt;
  logic [7:0]       r_data;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_inc;
  logic             w_start;
  logic             w_accept;
  logic             w_last;
  logic [7:0]       w_first_sample;
  logic [7:0]       w_next_sample;

  assign w_start     = start && ((r_state == c_st_idle) || (r_state == c_st_done));
  assign w_accept    = (r_state == c_st_run) && o_ready;
  assign w_count_inc = r_count + CNT_W'(1);
  assign w_last      = (w_count_inc == r_num);

  always_comb begin
    w_first_sample = const_val;
    case (mode)
      c_mode_ramp: w_first_sample = 8'h00;
      c_mode_lfsr: w_first_sample = LFSR_SEED;
      default:     w_first_sample = const_val;
    endcase
  end

  // Alternating mode simply inverts the previous sample.
  always_comb begin
    w_next_sample = ~r_data;
    case (r_mode)
      c_mode_ramp:  w_next_sample = r_data + r_step;
      c_mode_lfsr:  w_next_sample = {r_data[6:0], r_data[7] ^ r_data[5] ^ r_data[4] ^ r_data[3]};
      c_mode_const: w_next_sample = r_const;
      default:      w_next_sample = ~r_data;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= c_st_idle;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_idle, c_st_done: begin
        if (start) w_state_nxt = (num_samples == '0) ? c_st_done : c_st_run;
      end
      c_st_run: begin
        if (o_ready) begin
          if (w_last)              w_state_nxt = c_st_done;
          else if (r_gap == 4'd0)  w_state_nxt = c_st_run;
          else                     w_state_nxt = c_st_gap;
        end
      end
      c_st_gap: begin
        if (r_gap_cnt == 4'd1) w_state_nxt = c_st_run;
      end
      default: w_state_nxt = c_st_idle;
    endcase
  end

  // Output decode
  always_comb begin
    o_valid = (r_state == c_st_run);
    busy    = (r_state == c_st_run) || (r_state == c_st_gap);
    done    = (r_state == c_st_done);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode    <= 2'b00;
      r_num     <= '0;
      r_step    <= 8'h00;
      r_const   <= 8'h00;
      r_gap     <= 4'd0;
      r_gap_cnt <= 4'd0;
      r_data    <= 8'h00;
      r_count   <= '0;
    end else if (w_start) begin
      r_mode  <= mode;
      r_num   <= num_samples;
      r_step  <= step;
      r_const <= const_val;
      r_gap   <= gap;
      r_count <= '0;
      if (num_samples != '0) r_data <= w_first_sample;
    end else if (w_accept) begin
      r_data    <= w_next_sample;
      r_gap_cnt <= r_gap;
      if (r_count != r_num) r_count <= w_count_inc;
    end else if (r_state == c_st_gap) begin
      r_gap_cnt <= r_gap_cnt - 4'd1;
    end
  end

  assign o_data     = r_data;
  assign sent_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_sample_source.sv
`default_nettype none
// ============================================================================
// Module      : tb_sample_source
// Description : Scoreboard bench for sample_source.
// Revision    : 1.0
// ============================================================================
module tb_sample_source;

  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [1:0]       mode;
  logic [CNT_W-1:0] num_samples;
  logic [7:0]       step;
  logic [7:0]       const_val;
  logic [3:0]       gap;
  logic             o_valid;
  logic             o_ready;
  logic [7:0]       o_data;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] sent_count;

  int         n_tests = 0;
  int         n_fail  = 0;
  int         valid_seen = 0;
  logic [7:0] sb[$];
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data  = 8'h00;

  sample_source #(.CNT_W(CNT_W), .LFSR_SEED(8'hA5)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
    .num_samples(num_samples), .step(step), .const_val(const_val), .gap(gap),
    .o_valid(o_valid), .o_ready(o_ready), .o_data(o_data),
    .busy(busy), .done(done), .sent_count(sent_count)
  );

  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected sample sequence, computed from the pattern definitions.
  task automatic push_run(input logic [1:0] m, input int n, input logic [7:0] st, input logic [7:0] cv);
    logic [7:0] v;
    case (m)
      2'b00:   v = 8'h00;
      2'b01:   v = 8'hA5;
      default: v = cv;
    endcase
    for (int i = 0; i < n; i++) begin
      sb.push_back(v);
      case (m)
        2'b00:   v = v + st;
        2'b01:   v = {v[6:0], ^(v & 8'hB8)};
        2'b10:   v = cv;
        default: v = ~v;
      endcase
    end
  endtask

  task automatic do_start(input logic [1:0] m, input int n, input logic [7:0] st,
                          input logic [7:0] cv, input logic [3:0] g);
    mode = m; num_samples = CNT_W'(n); step = st; const_val = cv; gap = g;
    start = 1'b1;
    push_run(m, n, st, cv);
    tick();
    start = 1'b0;
    mode = ~m; num_samples = CNT_W'($urandom_range(1, 50)); step = 8'($urandom);
    const_val = 8'($urandom); gap = 4'($urandom);
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    while (!done && k < budget) begin
      tick();
      k++;
    end
    check_value("done_timeout", done, 1);
  endtask

  always @(negedge clk) begin
    if (rst_n && o_valid) begin
      valid_seen++;
      if (prev_stall) check_value("stall_hold", o_data, prev_data);
      if (o_ready) begin
        if (sb.size() == 0) check_value("sb_underflow", 1, 0);
        else                check_value("data", o_data, sb.pop_front());
      end
      prev_stall = !o_ready;
      prev_data  = o_data;
    end else begin
      prev_stall = 1'b0;
    end
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; mode = 2'b00; num_samples = '0; step = 8'h00;
    const_val = 8'h00; gap = 4'd0; o_ready = 1'b0;
    #1;
    check_value("rst_valid", o_valid, 0);
    check_value("rst_data", o_data, 0);
    check_value("rst_busy", busy, 0);
    check_value("rst_done", done, 0);
    check_value("rst_count", sent_count, 0);
    repeat (2) tick();
    @(negedge clk) rst_n = 1'b1;
    tick();

    // Ramp, back to back
    o_ready = 1'b1;
    do_start(2'b00, 4, 8'd3, 8'h00, 4'd0);
    for (int i = 0; i < 4; i++) begin
      check_value("t1_valid", o_valid, 1);
      tick();
    end
    check_value("t1_valid_drop", o_valid, 0);
    check_value("t1_done", done, 1);
    check_value("t1_count", sent_count, 4);

    // Ramp wrap
    do_start(2'b00, 3, 8'h80, 8'h00, 4'd0);
    wait_done(20);
    check_value("t2_count", sent_count, 3);

    // LFSR with stalls
    do_start(2'b01, 3, 8'h00, 8'h00, 4'd0);
    o_ready = 1'b1; tick();
    o_ready = 1'b0; tick();
    o_ready = 1'b1; tick();
    o_ready = 1'b0; tick();
    o_ready = 1'b1; tick();
    check_value("t3_done", done, 1);
    check_value("t3_count", sent_count, 3);

    // Alternating with gap=2
    do_start(2'b11, 4, 8'h00, 8'h3C, 4'd2);
    for (int i = 0; i < 10; i++) begin
      check_value("t4_valid", o_valid, (i % 3) == 0);
      check_value("t4_busy", busy, 1);
      tick();
    end
    check_value("t4_done", done, 1);
    check_value("t4_busy_end", busy, 0);

    // num=0, then start while busy
    valid_seen = 0;
    do_start(2'b10, 0, 8'h00, 8'h11, 4'd0);
    check_value("t5_done", done, 1);
    check_value("t5_count", sent_count, 0);
    tick();
    check_value("t5_no_valid", valid_seen, 0);
    do_start(2'b00, 4, 8'd7, 8'h00, 4'd1);
    tick();
    start = 1'b1; mode = 2'b10; num_samples = 1;
    tick();
    start = 1'b0;
    wait_done(30);
    check_value("t5_count_mid", sent_count, 4);

    // Asynchronous reset during a stall
    o_ready = 1'b1;
    do_start(2'b00, 4, 8'd5, 8'h00, 4'd0);
    tick();
    o_ready = 1'b0;
    tick();
    #2 rst_n = 1'b0;
    #1;
    check_value("t6_valid", o_valid, 0);
    check_value("t6_data", o_data, 0);
    check_value("t6_busy", busy, 0);
    check_value("t6_count", sent_count, 0);
    sb.delete();
    tick();
    @(negedge clk) rst_n = 1'b1;
    tick();
    check_value("t6_idle", busy, 0);
    o_ready = 1'b1;
    do_start(2'b00, 4, 8'd5, 8'h00, 4'd0);
    wait_done(20);
    check_value("t6_restart_count", sent_count, 4);

    check_value("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sample_source.md
Name: sample_source

Overview:
- Stimulus transmitter for the averaging filter's 8-bit sample input; the filter consumes what this block produces.
- Generates a programmed number of samples from one of four pattern generators and presents them on a valid/ready handshake.
- Supports optional idle gaps between samples, a sticky completion flag and an accepted-sample count for the monitor side.

Parameters:
- CNT_W, 16, width of num_samples and sent_count.
- LFSR_SEED, 8'hA5, first LFSR sample; must be nonzero.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  single-cycle request to begin a run; sampled only in IDLE or DONE.
- mode  input  2  00 ramp, 01 LFSR, 10 constant, 11 alternating; latched at start.
- num_samples  input  CNT_W  samples in the run; latched at start.
- step  input  8  ramp increment; latched at start.
- const_val  input  8  constant/alternating base value; latched at start.
- gap  input  4  idle cycles inserted after each accepted sample; latched at start.
- o_valid  output  1  o_data holds a valid sample.
- o_ready  input  1  consumer accepts when o_valid && o_ready.
- o_data  output  8  sample value.
- busy  output  1  high in RUN and GAP.
- done  output  1  sticky run-complete flag.
- sent_count  output  CNT_W  samples accepted in the current or last run.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, o_valid=0, o_data=0, busy=0, done=0, sent_count=0, all latched config=0. Reset mid-run aborts immediately. No sample is completed after reset.
- States: IDLE, RUN, GAP, DONE.
- IDLE or DONE, start=1, num_samples>0:
  - Latch config, clear done and sent_count, load the first sample.
  - Next cycle: state=RUN, o_valid=1.
  - Start-to-first-valid latency is 1 cycle.
- IDLE or DONE, start=1, num_samples=0: next cycle state=DONE, done=1, sent_count=0; o_valid never asserts.
- start while busy is ignored. Config inputs are ignored except on an accepted start.
- RUN, o_valid=1, o_ready=0: o_data and o_valid hold stable, with no limit on the number of stall cycles.
- RUN, on accept (o_valid && o_ready):
  - sent_count increments.
  - The next sample is computed into o_data in the same edge.
  - If the new sent_count equals num_samples: next state=DONE, o_valid=0, done=1.
  - Else if gap=0: stay in RUN with o_valid=1, giving back-to-back samples at 1 per cycle.
  - Else: enter GAP with o_valid=0.
- GAP: holds o_valid=0 for exactly gap cycles, then returns to RUN with o_valid=1 and the already-computed sample. o_ready is ignored in GAP.
- DONE: o_valid=0, done=1 and o_data hold until the next accepted start.
- Pattern rules (all arithmetic mod 256):
  - Ramp: first=0; next=prev+step.
  - LFSR: first=LFSR_SEED; next={prev[6:0], prev[7]^prev[5]^prev[4]^prev[3]}.
  - Constant: every sample = const_val.
  - Alternating: const_val, ~const_val, const_val, ...
- sent_count saturates at num_samples, so it cannot wrap within a run.

Test Plan:
1. Ramp, step=3, num=4, gap=0, o_ready=1: start → o_data 00,03,06,09 on 4 consecutive cycles; o_valid drops; done=1; sent_count=4.
2. Ramp wrap, step=0x80, num=3: samples 00,80,00; done=1.
3. LFSR, num=3, o_ready toggling 1,0,1,0,1: samples A5,4A,95; each value held stable during stall cycles; sent_count=3.
4. Alternating, const_val=0x3C, num=4, gap=2, o_ready=1: samples 3C,C3,3C,C3; exactly 2 idle cycles between each; busy high throughout; last valid to done=1 takes 1 cycle.
5. num=0 start → done=1 the next cycle with no o_valid pulse. A start asserted mid-run is ignored (sent_count continues).
6. Assert rst_n low during the 2nd sample's stall → all outputs 0 asynchronously. A new start after release restarts from the first pattern value.
